// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module  : muldiv_pkg
// Brief   : Shared funct3 encodings, FSM state type and op-decode helpers
//           for the RV32IM multiply/divide unit.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_CALC = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_signed_a(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_iter.sv
// ============================================================================
// Module  : muldiv_iter
// Brief   : Combinational radix-2 step: shift-add multiply or restoring
//           shift-subtract divide on the 2*XLEN accumulator.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  input  logic              div_mode,
  output logic [2*XLEN-1:0] acc_next,
  output logic              q_bit
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_rem_sh;
  logic [XLEN:0] w_diff;

  always_comb begin
    w_sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
    w_rem_sh = acc[2*XLEN-1:XLEN-1];
    // rem_sh < 2*divisor, so the difference always fits in XLEN+1 signed bits
    w_diff   = w_rem_sh - {1'b0, operand};
    q_bit    = ~w_diff[XLEN];
    if (div_mode) begin
      // bit 0 is the quotient slot; the caller inserts q_bit
      acc_next = {(q_bit ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0]), acc[XLEN-2:0], 1'b0};
    end else begin
      acc_next = {w_sum, acc[XLEN-1:1]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module  : muldiv_unit
// Brief   : Multi-cycle RV32IM M-extension unit: FSM, iteration counter,
//           sign fixup, divide fast paths and the result register.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int c_CNT_W = $clog2(XLEN);

  state_t              r_state, w_state_next;
  logic [2:0]          r_op;
  logic [XLEN-1:0]     r_a, r_b;
  logic                r_sign_a, r_sign_b;
  logic [2*XLEN-1:0]   r_acc;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]     r_result;

  logic                w_div, w_sa, w_sb, w_div_zero, w_ovf, w_fast, w_q_bit, w_last;
  logic [XLEN-1:0]     w_mag_a, w_mag_b, w_fast_res, w_quot, w_rem, w_calc_res;
  logic [2*XLEN-1:0]   w_acc_iter, w_acc_step, w_prod;

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .acc      (r_acc),
    .operand  (w_div ? r_b : r_a),
    .div_mode (w_div),
    .acc_next (w_acc_iter),
    .q_bit    (w_q_bit)
  );

  always_comb begin
    w_div      = is_div(r_op);
    w_sa       = is_signed_a(r_op) & r_a[XLEN-1];
    w_sb       = is_signed_b(r_op) & r_b[XLEN-1];
    w_mag_a    = w_sa ? -r_a : r_a;
    w_mag_b    = w_sb ? -r_b : r_b;
    w_div_zero = w_div && (r_b == '0);
    w_ovf      = w_div && is_signed_a(r_op) && (r_a == {1'b1, {(XLEN-1){1'b0}}}) && (r_b == '1);
    w_fast     = w_div_zero || w_ovf;
    // op[1] selects remainder within the divide group
    if (r_op[1]) w_fast_res = w_div_zero ? r_a : '0;
    else         w_fast_res = w_div_zero ? '1 : r_a;

    w_acc_step = {w_acc_iter[2*XLEN-1:1], w_acc_iter[0] | (w_div & w_q_bit)};
    w_prod     = (r_sign_a ^ r_sign_b) ? -w_acc_step : w_acc_step;
    w_quot     = (r_sign_a ^ r_sign_b) ? -w_acc_step[XLEN-1:0] : w_acc_step[XLEN-1:0];
    w_rem      = r_sign_a ? -w_acc_step[2*XLEN-1:XLEN] : w_acc_step[2*XLEN-1:XLEN];
    if (w_div)              w_calc_res = r_op[1] ? w_rem : w_quot;
    else if (r_op == OP_MUL) w_calc_res = w_prod[XLEN-1:0];
    else                    w_calc_res = w_prod[2*XLEN-1:XLEN];
    w_last     = (r_cnt == '0);
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_PREP;
      S_PREP:  w_state_next = w_fast ? S_FIN : S_CALC;
      S_CALC:  if (w_last) w_state_next = S_FIN;
      S_FIN:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (flush) w_state_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start && !flush) begin
          r_op <= op;
          r_a  <= rs1;
          r_b  <= rs2;
        end
        S_PREP: begin
          r_sign_a <= w_sa;
          r_sign_b <= w_sb;
          r_a      <= w_mag_a;
          r_b      <= w_mag_b;
          r_acc    <= {{XLEN{1'b0}}, (w_div ? w_mag_a : w_mag_b)};
          r_cnt    <= c_CNT_W'(XLEN - 1);
          if (w_fast && !flush) r_result <= w_fast_res;
        end
        S_CALC: begin
          r_acc <= w_acc_step;
          r_cnt <= r_cnt - c_CNT_W'(1);
          if (w_last && !flush) r_result <= w_calc_res;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_FIN);
  assign result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module  : tb_muldiv_unit
// Brief   : Directed self-checking bench for muldiv_unit (XLEN=32).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1, rs2;
  logic            flush;
  logic            busy, done;
  logic [XLEN-1:0] result;

  int n_checks = 0;
  int n_fails  = 0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .rs1    (rs1),
    .rs2    (rs2),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the accept edge is the next posedge (cycle 0 -> 1).
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat, input string tag);
    int   cyc;
    logic busy_ok;
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    busy_ok = 1'b1;
    while (!done && cyc < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    if (!busy) busy_ok = 1'b0;
    check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, " result"}, result, exp_res);
    check({tag, " busy held"}, {31'd0, busy_ok}, 32'd1);
    @(negedge clk);
    check({tag, " done single"}, {31'd0, done}, 32'd0);
    check({tag, " busy after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int   cyc;
    logic done_seen;
    rst_n = 1'b0; start = 1'b0; op = 3'd0; rs1 = '0; rs2 = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(OP_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "MUL 7*-3");
    run_op(OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, "MULH min*min");
    run_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "MULHU max*max");
    run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "MULHSU -1*max");
    run_op(OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, "DIV -7/2");
    run_op(OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, "REM -7/2");
    run_op(OP_DIVU,   32'd100,       32'd7,         32'd14,        34, "DIVU 100/7");
    run_op(OP_REMU,   32'd100,       32'd7,         32'd2,         34, "REMU 100/7");
    run_op(OP_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 2,  "DIV 5/0");
    run_op(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2,  "DIV ovf");
    run_op(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2,  "REM ovf");
    run_op(OP_REMU,   32'd5,         32'd0,         32'd5,         2,  "REMU 5/0");

    // Flush mid-divide with stray START pulses; RESULT must stay at 5
    start = 1'b1; op = OP_DIVU; rs1 = 32'd1000; rs2 = 32'd10;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 10) begin
      start = (cyc == 3);
      op = OP_MUL; rs1 = 32'd1; rs2 = 32'd1;
      @(negedge clk);
      cyc++;
    end
    flush = 1'b1; start = 1'b1;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    check("flush busy", {31'd0, busy}, 32'd0);
    check("flush done", {31'd0, done}, 32'd0);
    check("flush result", result, 32'd5);
    done_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) done_seen = 1'b1;
    end
    check("flush quiet", {31'd0, done_seen}, 32'd0);
    check("flush result held", result, 32'd5);
    run_op(OP_MUL, 32'd3, 32'd4, 32'd12, 34, "MUL 3*4");

    // Asynchronous reset in the middle of a multiply
    start = 1'b1; op = OP_MUL; rs1 = 32'h1234; rs2 = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst busy", {31'd0, busy}, 32'd0);
    check("async rst done", {31'd0, done}, 32'd0);
    check("async rst result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(OP_DIVU, 32'd9, 32'd3, 32'd3, 34, "DIVU 9/3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
